// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MAX_REQ    = 4;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Wide enough to index up to MAX_REQ requesters.
  typedef logic [1:0] grant_idx_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational priority selector: searches the request vector starting at
// start_i and wrapping, returning a one-hot grant, its index and a valid flag.
module rr_priority_select
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  grant_idx_t        start_i,
  output logic [NumReq-1:0] gnt_o,
  output grant_idx_t        idx_o,
  output logic              any_o
);

  int unsigned j;

  // First valid requester at or after start_i (mod NumReq) wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      j = 32'(start_i) + k;
      if (j >= NumReq) begin
        j = j - NumReq;
      end
      if (!any_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = grant_idx_t'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with index 0 highest and no pointer state.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          hold,
  output logic                          rf_write_en,
  output logic [REG_ADDR_W-1:0]         rf_write_addr,
  output logic [XLEN-1:0]               rf_write_data,
  output grant_idx_t                    grant_idx
);

  logic [NUM_REQ-1:0]    req_eff;
  logic [NUM_REQ-1:0]    gnt;
  grant_idx_t            gnt_idx;
  logic                  gnt_any;
  grant_idx_t            start;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [XLEN-1:0]       wr_data_q;
  grant_idx_t            wr_idx_q;

  // No grants during reset or stall.
  assign req_eff = (rst || hold) ? '0 : req_valid;

`ifdef WB_ARB_ROUND_ROBIN_EN
  grant_idx_t ptr_d, ptr_q;

  // Pointer moves just past the granted requester; unchanged without a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == grant_idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 2'd1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  rr_priority_select #(
    .NumReq (NUM_REQ)
  ) u_select (
    .req_i   (req_eff),
    .start_i (start),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign req_ready = gnt;

  // Route the granted requester's address and data using the one-hot grant.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Output stage: x0 writes complete the handshake but never assert the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_idx_q  <= '0;
    end else begin
      wr_en_q <= gnt_any && (sel_addr != ZERO_REG);
      if (gnt_any && (sel_addr != ZERO_REG)) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        wr_idx_q  <= gnt_idx;
      end
    end
  end

  // A staged write is discarded if reset arrives before it reaches the file.
  assign rf_write_en   = wr_en_q && !rst;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;
  assign grant_idx     = wr_idx_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with three requesters.
module tb_regfile_wb_arbiter;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  g;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*5-1:0]    req_addr;
  logic [N*32-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              hold;
  logic              rf_write_en;
  logic [4:0]        rf_write_addr;
  logic [31:0]       rf_write_data;
  logic [1:0]        grant_idx;

  wr_t               sb_q[$];
  logic [1:0]        ptr_m;
  logic [N-1:0]      pend_m;
  logic [N*5-1:0]    addr_prev;
  logic [N*32-1:0]   data_prev;
  logic [31:0]       shadow [32];
  int                n_tests;
  int                n_fail;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ (N),
    .XLEN    (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .hold          (hold),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .grant_idx     (grant_idx)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic r,
                                               input logic h, input logic [1:0] p);
    logic [N-1:0] res;
    int unsigned  j;
    res = '0;
    if (!r && !h) begin
      for (int unsigned k = 0; k < N; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        j = (32'(p) + k) % N;
`else
        j = k;
`endif
        if (res == '0 && v[j]) res[j] = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]      = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  // One clock: check pre-edge outputs against the model, then advance the model.
  task automatic step();
    logic [N-1:0] er;
    wr_t          w;
    #3;
    er = model_ready(req_valid, rst, hold, ptr_m);
    check_eq("req_ready", 64'(req_ready), 64'(er));
    for (int i = 0; i < N; i++) begin
      if (pend_m[i] && !rst) begin
        check_eq("proto_valid", 64'(req_valid[i]), 64'd1);
        check_eq("proto_addr", 64'(req_addr[i*5 +: 5]), 64'(addr_prev[i*5 +: 5]));
        check_eq("proto_data", 64'(req_data[i*32 +: 32]), 64'(data_prev[i*32 +: 32]));
      end
    end
    check_eq("rf_write_en", 64'(rf_write_en), 64'((sb_q.size() != 0) && !rst));
    if (sb_q.size() != 0 && !rst) begin
      w = sb_q.pop_front();
      check_eq("rf_write_addr", 64'(rf_write_addr), 64'(w.a));
      check_eq("rf_write_data", 64'(rf_write_data), 64'(w.d));
      check_eq("grant_idx", 64'(grant_idx), 64'(w.g));
    end
    if (rf_write_en) shadow[rf_write_addr] = rf_write_data;
    @(posedge clk);
    if (rst) begin
      ptr_m  = '0;
      pend_m = '0;
      sb_q.delete();
    end else begin
      pend_m = req_valid & ~er;
      for (int i = 0; i < N; i++) begin
        if (er[i]) begin
          if (req_addr[i*5 +: 5] != 5'd0)
            sb_q.push_back('{a: req_addr[i*5 +: 5], d: req_data[i*32 +: 32], g: 2'(i)});
`ifdef WB_ARB_ROUND_ROBIN_EN
          ptr_m = 2'((i + 1) % N);
`endif
        end
      end
    end
    addr_prev = req_addr;
    data_prev = req_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ptr_m     = '0;
    pend_m    = '0;
    addr_prev = '0;
    data_prev = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 1'b1, 5'd3, 32'h0000_0A03);
    set_req(1, 1'b1, 5'd4, 32'h0000_0B04);
    @(negedge clk);

    // Reset with requests pending: no grants, no writes, zeroed outputs.
    step();
    step();
    check_eq("rst_addr", 64'(rf_write_addr), 64'd0);
    check_eq("rst_data", 64'(rf_write_data), 64'd0);
    check_eq("rst_idx", 64'(grant_idx), 64'd0);
    rst = 1'b0;
    check_eq("first_grant", 64'(model_ready(req_valid, rst, hold, ptr_m)), 64'd1);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    step();

    // Single write from requester 1.
    set_req(1, 1'b1, 5'd5, 32'hABCD_EFFF);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    step();

    // Write to x0 is accepted but never reaches the file.
    set_req(0, 1'b1, 5'd0, 32'h1234_5678);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    step();
    step();
    check_eq("x0_read", 64'(shadow[0]), 64'd0);

    // All three continuously valid: round-robin rotates, fixed priority starves.
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1111_0001);
    set_req(1, 1'b1, 5'd2, 32'h2222_0002);
    set_req(2, 1'b1, 5'd3, 32'h3333_0003);
    for (int c = 0; c < 6; c++) step();
    step();
    req_valid = '0;
    do_reset();

    // Accepted write completes even as hold rises; later cycles stay idle.
    set_req(0, 1'b1, 5'd7, 32'h0000_0777);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd8, 32'h0000_0888);
    hold = 1'b1;
    step();
    step();
    step();
    hold = 1'b0;
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    step();
    check_eq("hold_write7", 64'(shadow[7]), 64'h777);

    // Reset the cycle after an acceptance: the staged write is dropped.
    set_req(2, 1'b1, 5'd9, 32'h0000_0999);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    check_eq("rst_drop_x9", 64'(shadow[9]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among several writeback requesters (ALU result, load unit, multi-cycle mul/div). Each requester presents a valid/ready write request. The block grants one request per cycle and drives the register file write port from a registered stage. Writes to x0 are accepted but never reach the register file.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- XLEN, 32: data width.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*5  destination register; requester i uses bits [5i+4:5i].
- req_data  in  NUM_REQ*XLEN  write data; requester i uses slice i.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- hold  in  1  pipeline stall; while high, no grants are issued.
- rf_write_en  out  1  register file write enable.
- rf_write_addr  out  5  register file write address.
- rf_write_data  out  XLEN  register file write data.
- grant_idx  out  2  index of the requester accepted in the previous cycle; valid only when rf_write_en is high.

## Operation
- **Grant selection** is combinational from req_valid, hold and the priority pointer ptr.
  - req_ready has at most one bit set.
  - req_ready is all zero when hold=1 or when no request is valid.
- **Ready independence:** req_ready[i] never depends on req_ready[j] or on any downstream signal. The register file has no backpressure.
- **Requester protocol:**
  - Once asserted, a request holds valid, addr and data stable until accepted.
  - The arbiter does not check this; the bench asserts it.
- **Accepted request to a nonzero address:** on the next edge the output register loads rf_write_en=1 with that request's addr, data and index.
- **Accepted request to x0:** the handshake completes (ready=1) and ptr advances, but the output register loads rf_write_en=0. x0 stays 0.
- **No accepted request:** rf_write_en=0 at the next edge. Addr, data and grant_idx hold their previous values.
- **Priority pointer:**
  - ptr is 2 bits and resets to 0.
  - After a grant to index g, ptr becomes (g+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
  - ptr is unchanged in cycles with no grant.
- **Reset values:** rf_write_en=0, rf_write_addr=0, rf_write_data=0, grant_idx=0, ptr=0.
  - req_ready is all zero while rst=1, even when requests are valid.

## Timing
- **Latency:** exactly 1 cycle from the accepting edge to rf_write_en being high. Throughput is one write per cycle.
- **Back-to-back acceptances** on consecutive cycles give consecutive rf_write_en pulses with no bubble.
- **hold:**
  - hold rising while a write is in the output stage does not cancel that write. It completes in its cycle.
  - While hold is high, later cycles carry rf_write_en=0.
- **Reset mid-operation:**
  - An accepted-but-not-yet-written request is discarded. rf_write_en=0 in the cycle after rst.
  - The requester must treat that request as lost. The pipeline flushes on reset anyway.
- **Simultaneous requests to the same register:** the two writes are serialized in grant order, so the later-granted data wins.

## Configuration
- **WB_ARB_ROUND_ROBIN_EN defined:**
  - The search starts at ptr and wraps. The first valid requester wins.
  - Every requester that stays valid is granted within NUM_REQ cycles.
- **WB_ARB_ROUND_ROBIN_EN undefined:**
  - Fixed priority, with index 0 highest. ptr is not instantiated.
  - Lower-index requesters can starve higher-index ones. This is intended for single-issue builds where only the load unit competes with the ALU.

## Structure
- **Package regfile_arb_pkg:**
  - REG_ADDR_W=5.
  - MAX_REQ=4.
  - ZERO_REG=5'd0.
  - The grant index type (2 bits).
- **Sub-module rr_priority_select:**
  - Purely combinational.
  - Inputs: request vector, start pointer.
  - Outputs: one-hot grant, grant index, any-grant flag.
  - Under fixed priority, the start pointer is tied to 0.
- The top level holds only ptr, the output register and the x0 filter.

## Test plan
- **Reset:** rst=1 for 2 cycles with req_valid=2'b11 -> req_ready=00, rf_write_en=0. After release, the first grant goes to index 0.
- **Single write:** requester 1 sends addr=5, data=32'hABCDEFFF -> req_ready=10 that cycle. Next cycle rf_write_en=1, rf_write_addr=5, rf_write_data=ABCDEFFF, grant_idx=1.
- **x0 drop:** requester 0 sends addr=0, data=32'h12345678 -> accepted (ready=01), rf_write_en stays 0, and a later read of x0 returns 00000000.
- **Round-robin (macro on):**
  - Stimulus: NUM_REQ=3, all requesters continuously valid with distinct addrs 1, 2, 3.
  - Response: grants are 0,1,2,0,1,2 on consecutive cycles, and rf_write_en is high on 6 consecutive cycles.
- **Fixed priority (macro off):** the same stimulus grants index 0 every cycle, and requesters 1 and 2 stay not-ready.
- **hold and reset mid-flight:**
  - Stimulus: request to addr=7 accepted, then hold=1 the next cycle.
  - Response: addr 7 is written, then rf_write_en=0 while hold is high.
  - Stimulus: separately, assert rst the cycle after an acceptance.
  - Response: no write occurs.
